// File: rtl/sub_bytes_seq.sv
// Byte-serial AES SubBytes: issues the 16 state bytes one per cycle to an external
// sbox of latency SBOX_LAT, reassembles the results and presents them with a valid/ready handshake.
module sub_bytes_seq #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [7:0]   sb_x,
  input  logic [7:0]   sb_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         r_state;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [3:0]     r_cnt;
  logic [127:0]   r_data;
  logic [127:0]   r_out;

  logic           w_issue;
  logic           w_cap_v;
  logic [3:0]     w_cap_idx;
  logic           w_cap;

  assign w_issue = (r_state == ISSUE);

  // Byte k sits at bit offset 8*(15-k); ~k equals 15-k for a 4-bit index.
  assign sb_x = w_issue ? r_data[{~r_cnt, 3'b000} +: 8] : 8'h00;

  generate
    if (SBOX_LAT == 0) begin : g_lat0
      assign w_cap_v   = w_issue;
      assign w_cap_idx = r_cnt;
    end else begin : g_tag_pipe
      logic [SBOX_LAT-1:0] r_tag_v;
      logic [3:0]          r_tag_idx [SBOX_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag_v <= '0;
          for (int i = 0; i < SBOX_LAT; i++) r_tag_idx[i] <= 4'd0;
        end else begin
          r_tag_v[0]   <= w_issue;
          r_tag_idx[0] <= r_cnt;
          for (int i = 1; i < SBOX_LAT; i++) begin
            r_tag_v[i]   <= r_tag_v[i-1];
            r_tag_idx[i] <= r_tag_idx[i-1];
          end
        end
      end

      assign w_cap_v   = r_tag_v[SBOX_LAT-1];
      assign w_cap_idx = r_tag_idx[SBOX_LAT-1];
    end
  endgenerate

  // A tag that survives into IDLE or DONE must never overwrite a presented result.
  assign w_cap = w_cap_v && (r_state == ISSUE || r_state == DRAIN);

  // NOTE: every register here uses <= so all of them see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= 4'd0;
      r_data      <= '0;
      r_out       <= '0;
    end else begin
      if (w_cap) r_out[{~w_cap_idx, 3'b000} +: 8] <= sb_y;

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_cnt      <= 4'd0;
            r_in_ready <= 1'b0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'hf) begin
            if (SBOX_LAT == 0) begin
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_cap && w_cap_idx == 4'hf) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;

endmodule
